// File: rtl/core_pkg.sv
// core_pkg: types and bus-width defaults shared by the core data path.
// Owner-state encoding for the data-memory arbiter lives here.
package core_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  function automatic owner_e own_of(input logic idx);
    return idx ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker with a saturating burst counter.
// The current owner keeps the port for up to BURST_P grants under contention.
module rr_arb2
  import core_pkg::*;
#(
  parameter int unsigned BURST_P = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output logic       o_gnt_idx
);

  localparam int unsigned CW = $clog2(BURST_P + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_P);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  owner_e        r_state;
  owner_e        w_state_nxt;
  logic          r_last;
  logic          w_last_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic w_owned;
  logic w_owner_idx;
  logic w_hold;
  logic w_any;
  logic w_idx;

  assign w_owned     = (r_state != IDLE);
  assign w_owner_idx = (r_state == OWN1);
  assign w_hold      = w_owned && (r_cnt < CNT_MAX);

  // Under contention the owner keeps the port until its burst is spent.
  always_comb begin
    w_any = 1'b1;
    w_idx = 1'b0;
    unique case (1'b1)
      (i_req == 2'b11): w_idx = w_hold ? w_owner_idx : ~r_last;
      (i_req == 2'b01): w_idx = 1'b0;
      (i_req == 2'b10): w_idx = 1'b1;
      default:          w_any = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = IDLE;
    w_cnt_nxt   = '0;
    w_last_nxt  = r_last;
    if (w_any) begin
      w_state_nxt = own_of(w_idx);
      w_last_nxt  = w_idx;
      if (w_owned && (w_idx == w_owner_idx))
        w_cnt_nxt = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_ONE;
      else
        w_cnt_nxt = CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_gnt     = w_any ? (w_idx ? 2'b10 : 2'b01) : 2'b00;
  assign o_gnt_idx = w_idx;

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one synchronous data-memory port between the
// core load/store path (r0) and the loader/debug DMA (r1).
module data_mem_arbiter
  import core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_P      = DATA_WIDTH,
  parameter int unsigned DATA_ADDR_WIDTH_P = ADDR_WIDTH,
  parameter int unsigned BURST_P           = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_r0_req,
  input  logic                         i_r0_we,
  input  logic [DATA_ADDR_WIDTH_P-1:0] i_r0_addr,
  input  logic [DATA_WIDTH_P-1:0]      i_r0_wr_data,
  output logic                         o_r0_gnt,
  output logic                         o_r0_rvalid,
  output logic [DATA_WIDTH_P-1:0]      o_r0_rd_data,
  input  logic                         i_r1_req,
  input  logic                         i_r1_we,
  input  logic [DATA_ADDR_WIDTH_P-1:0] i_r1_addr,
  input  logic [DATA_WIDTH_P-1:0]      i_r1_wr_data,
  output logic                         o_r1_gnt,
  output logic                         o_r1_rvalid,
  output logic [DATA_WIDTH_P-1:0]      o_r1_rd_data,
  output logic                         o_mem_en,
  output logic                         o_mem_wr_en,
  output logic [DATA_ADDR_WIDTH_P-1:0] o_mem_addr,
  output logic [DATA_WIDTH_P-1:0]      o_mem_wr_data,
  input  logic [DATA_WIDTH_P-1:0]      i_mem_rd_data
);

  logic [1:0] w_req;
  logic [1:0] w_arb_gnt;
  logic       w_arb_idx;
  logic [1:0] w_gnt;
  logic       w_any;

  logic                         w_sel_we;
  logic [DATA_ADDR_WIDTH_P-1:0] w_sel_addr;
  logic [DATA_WIDTH_P-1:0]      w_sel_data;

  logic r_rvalid;
  logic r_rd_owner;

  assign w_req = {i_r1_req, i_r0_req};

  rr_arb2 #(
    .BURST_P (BURST_P)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_req     (w_req),
    .o_gnt     (w_arb_gnt),
    .o_gnt_idx (w_arb_idx)
  );

  // Grants are combinational, so mask them while reset is held.
  assign w_gnt = w_arb_gnt & {2{reset}};
  assign w_any = |w_gnt;

  assign o_r0_gnt = w_gnt[0];
  assign o_r1_gnt = w_gnt[1];

  assign w_sel_we   = w_arb_idx ? i_r1_we      : i_r0_we;
  assign w_sel_addr = w_arb_idx ? i_r1_addr    : i_r0_addr;
  assign w_sel_data = w_arb_idx ? i_r1_wr_data : i_r0_wr_data;

  assign o_mem_en      = w_any;
  assign o_mem_wr_en   = w_any & w_sel_we;
  assign o_mem_addr    = w_any ? w_sel_addr : '0;
  assign o_mem_wr_data = w_any ? w_sel_data : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rvalid   <= 1'b0;
      r_rd_owner <= 1'b0;
    end else begin
      r_rvalid <= w_any & ~w_sel_we;
      if (w_any)
        r_rd_owner <= w_arb_idx;
    end
  end

  assign o_r0_rvalid  = r_rvalid & ~r_rd_owner;
  assign o_r1_rvalid  = r_rvalid & r_rd_owner;
  assign o_r0_rd_data = o_r0_rvalid ? i_mem_rd_data : '0;
  assign o_r1_rd_data = o_r1_rvalid ? i_mem_rd_data : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed scenarios plus randomized traffic checked
// against a run-length round-robin model and a shadow memory.
module tb_data_mem_arbiter;
  import core_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_r0_req, i_r0_we, i_r1_req, i_r1_we;
  logic [AW-1:0] i_r0_addr, i_r1_addr;
  logic [DW-1:0] i_r0_wr_data, i_r1_wr_data;
  logic          o_r0_gnt, o_r0_rvalid, o_r1_gnt, o_r1_rvalid;
  logic [DW-1:0] o_r0_rd_data, o_r1_rd_data;
  logic          o_mem_en, o_mem_wr_en;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wr_data;
  logic [DW-1:0] mem_rd = '0;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  int tests = 0;
  int fails = 0;

  int            m_owner;
  int            m_run;
  int            m_last;
  bit            exp_rv [2];
  logic [DW-1:0] exp_rd;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .DATA_WIDTH_P      (DW),
    .DATA_ADDR_WIDTH_P (AW),
    .BURST_P           (BURST)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .i_r0_req      (i_r0_req),
    .i_r0_we       (i_r0_we),
    .i_r0_addr     (i_r0_addr),
    .i_r0_wr_data  (i_r0_wr_data),
    .o_r0_gnt      (o_r0_gnt),
    .o_r0_rvalid   (o_r0_rvalid),
    .o_r0_rd_data  (o_r0_rd_data),
    .i_r1_req      (i_r1_req),
    .i_r1_we       (i_r1_we),
    .i_r1_addr     (i_r1_addr),
    .i_r1_wr_data  (i_r1_wr_data),
    .o_r1_gnt      (o_r1_gnt),
    .o_r1_rvalid   (o_r1_rvalid),
    .o_r1_rd_data  (o_r1_rd_data),
    .o_mem_en      (o_mem_en),
    .o_mem_wr_en   (o_mem_wr_en),
    .o_mem_addr    (o_mem_addr),
    .o_mem_wr_data (o_mem_wr_data),
    .i_mem_rd_data (mem_rd)
  );

  // Synchronous memory: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (o_mem_en) begin
      if (o_mem_wr_en) mem[o_mem_addr[7:0]] = o_mem_wr_data;
      else             mem_rd = mem[o_mem_addr[7:0]];
    end
  end

  task automatic drive(input logic q0, input logic w0,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic q1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    i_r0_req = q0; i_r0_we = w0; i_r0_addr = a0; i_r0_wr_data = d0;
    i_r1_req = q1; i_r1_we = w1; i_r1_addr = a1; i_r1_wr_data = d1;
  endtask

  task automatic idle_in();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic m_reset();
    m_owner = -1; m_run = 0; m_last = 1;
    exp_rv[0] = 0; exp_rv[1] = 0; exp_rd = '0;
  endtask

  // Owner runs: contention keeps the owner until BURST grants, then flips.
  function automatic int pick(input bit a, input bit b);
    if (a && b) return (m_owner >= 0 && m_run < BURST) ? m_owner : 1 - m_last;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  task automatic m_commit(input int g, input bit we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_rv[0] = 0; exp_rv[1] = 0;
    if (g < 0) begin
      m_owner = -1; m_run = 0;
    end else begin
      m_run   = (g == m_owner) ? ((m_run < BURST) ? m_run + 1 : BURST) : 1;
      m_owner = g;
      m_last  = g;
      if (we) ref_mem[a[7:0]] = d;
      else begin exp_rv[g] = 1; exp_rd = ref_mem[a[7:0]]; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 32'h10, 32'hFFFF_FFFF, 1, 1, 32'h20, 32'h5);
    #1;
    tests++;
    if ({o_r1_gnt, o_r0_gnt, o_mem_en, o_mem_wr_en} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctl: got gnt=%b%b en=%b we=%b want 0",
               o_r1_gnt, o_r0_gnt, o_mem_en, o_mem_wr_en);
    end
    @(negedge clk); #1;
    tests++;
    if ({o_r1_rvalid, o_r0_rvalid, o_mem_addr, o_mem_wr_data,
         o_r0_rd_data, o_r1_rd_data} !== '0) begin
      fails++;
      $display("FAIL reset_data: got rv=%b%b addr=%h wd=%h want 0",
               o_r1_rvalid, o_r0_rvalid, o_mem_addr, o_mem_wr_data);
    end
    idle_in();
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    mem[8'h10] = 32'hDEAD_BEEF;
    @(negedge clk);
    drive(1, 0, 32'h10, '0, 0, 0, '0, '0);
    #1;
    tests++;
    if ({o_r0_gnt, o_r1_gnt, o_mem_en, o_mem_wr_en, o_r0_rvalid} !== 5'b10100
        || o_mem_addr !== 32'h10) begin
      fails++;
      $display("FAIL read_gnt: got g0=%b g1=%b en=%b we=%b rv=%b addr=%h want 1 0 1 0 0 10",
               o_r0_gnt, o_r1_gnt, o_mem_en, o_mem_wr_en, o_r0_rvalid, o_mem_addr);
    end
    @(negedge clk);
    idle_in();
    #1;
    tests++;
    if (o_r0_rvalid !== 1'b1 || o_r0_rd_data !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL read_ret: got rv=%b data=%h want 1 deadbeef",
               o_r0_rvalid, o_r0_rd_data);
    end
    tests++;
    if (o_r1_rvalid !== 1'b0 || o_r1_rd_data !== '0) begin
      fails++;
      $display("FAIL read_r1_quiet: got rv=%b data=%h want 0 0",
               o_r1_rvalid, o_r1_rd_data);
    end
    @(negedge clk); #1;
    tests++;
    if (o_r0_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL read_once: got rv=%b want 0", o_r0_rvalid);
    end
  endtask

  task automatic test_burst();
    int e;
    @(negedge clk);
    reset = 1'b0;
    idle_in();
    @(negedge clk);
    reset = 1'b1;
    drive(1, 1, 32'h40, 32'h1, 1, 1, 32'h44, 32'h2);
    for (int c = 0; c < 16; c++) begin
      #1;
      e = (c / BURST) % 2;
      tests++;
      if (o_r0_gnt !== (e == 0) || o_r1_gnt !== (e == 1)) begin
        fails++;
        $display("FAIL burst[%0d]: got g0=%b g1=%b want owner %0d",
                 c, o_r0_gnt, o_r1_gnt, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_r1_saturate();
    drive(0, 0, '0, '0, 1, 0, 32'h8, '0);
    for (int c = 0; c < 10; c++) begin
      #1;
      tests++;
      if (o_r1_gnt !== 1'b1 || o_r0_gnt !== 1'b0) begin
        fails++;
        $display("FAIL r1_alone[%0d]: got g0=%b g1=%b want 0 1",
                 c, o_r0_gnt, o_r1_gnt);
      end
      @(negedge clk);
    end
    drive(1, 0, 32'h4, '0, 1, 0, 32'h8, '0);
    #1;
    tests++;
    if (o_r0_gnt !== 1'b1 || o_r1_gnt !== 1'b0) begin
      fails++;
      $display("FAIL r0_joins: got g0=%b g1=%b want 1 0", o_r0_gnt, o_r1_gnt);
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_alternating();
    mem[8'h04] = 32'hA5A5_0004;
    mem[8'h08] = 32'h5A5A_0008;
    @(negedge clk);
    drive(1, 0, 32'h4, '0, 0, 0, '0, '0);
    #1;
    tests++;
    if (o_r0_gnt !== 1'b1) begin
      fails++;
      $display("FAIL alt_g0: got %b want 1", o_r0_gnt);
    end
    @(negedge clk);
    drive(0, 0, '0, '0, 1, 0, 32'h8, '0);
    #1;
    tests++;
    if ({o_r1_gnt, o_r0_rvalid, o_r1_rvalid} !== 3'b110
        || o_r0_rd_data !== 32'hA5A5_0004) begin
      fails++;
      $display("FAIL alt_rv0: got g1=%b rv=%b%b data=%h want 1 10 a5a50004",
               o_r1_gnt, o_r0_rvalid, o_r1_rvalid, o_r0_rd_data);
    end
    @(negedge clk);
    drive(0, 0, '0, '0, 1, 1, 32'h20, 32'h55);
    #1;
    tests++;
    if ({o_r1_rvalid, o_r0_rvalid} !== 2'b10 || o_r1_rd_data !== 32'h5A5A_0008) begin
      fails++;
      $display("FAIL alt_rv1: got rv=%b%b data=%h want 10 5a5a0008",
               o_r1_rvalid, o_r0_rvalid, o_r1_rd_data);
    end
    tests++;
    if ({o_r1_gnt, o_mem_en, o_mem_wr_en} !== 3'b111 || o_mem_addr !== 32'h20
        || o_mem_wr_data !== 32'h55) begin
      fails++;
      $display("FAIL alt_wr: got g1=%b en=%b we=%b addr=%h wd=%h want 1 1 1 20 55",
               o_r1_gnt, o_mem_en, o_mem_wr_en, o_mem_addr, o_mem_wr_data);
    end
    @(negedge clk);
    idle_in();
    #1;
    tests++;
    if ({o_r0_rvalid, o_r1_rvalid} !== 2'b00 || mem[8'h20] !== 32'h55) begin
      fails++;
      $display("FAIL alt_wr_done: got rv=%b%b mem=%h want 00 55",
               o_r0_rvalid, o_r1_rvalid, mem[8'h20]);
    end
  endtask

  task automatic test_idle();
    @(negedge clk);
    idle_in();
    #1;
    tests++;
    if ({o_mem_en, o_mem_wr_en} !== 2'b00 || o_mem_addr !== '0
        || o_mem_wr_data !== '0) begin
      fails++;
      $display("FAIL idle_port: got en=%b we=%b addr=%h wd=%h want 0",
               o_mem_en, o_mem_wr_en, o_mem_addr, o_mem_wr_data);
    end
    @(negedge clk); #1;
    tests++;
    if (u_dut.u_arb.r_state !== IDLE || u_dut.u_arb.r_cnt !== '0) begin
      fails++;
      $display("FAIL idle_state: got state=%0d cnt=%0d want 0 0",
               u_dut.u_arb.r_state, u_dut.u_arb.r_cnt);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(1, 0, 32'h10, '0, 0, 0, '0, '0);
    #1;
    tests++;
    if (o_r0_gnt !== 1'b1) begin
      fails++;
      $display("FAIL mid_gnt: got %b want 1", o_r0_gnt);
    end
    #2;
    reset = 1'b0;
    @(negedge clk);
    idle_in();
    #1;
    tests++;
    if ({o_r0_rvalid, o_r1_rvalid} !== 2'b00) begin
      fails++;
      $display("FAIL mid_rv: got rv=%b%b want 00", o_r0_rvalid, o_r1_rvalid);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1, 0, 32'h4, '0, 1, 0, 32'h8, '0);
    #1;
    tests++;
    if (o_r0_gnt !== 1'b1 || o_r1_gnt !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_tie: got g0=%b g1=%b want 1 0",
               o_r0_gnt, o_r1_gnt);
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_random();
    bit            pr [2];
    bit            pw [2];
    logic [AW-1:0] pa [2];
    logic [DW-1:0] pd [2];
    int            g, gi;
    logic [1:0]    eg;
    logic          een, ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    pr[0] = 0; pr[1] = 0;
    @(negedge clk);
    reset = 1'b0;
    idle_in();
    @(negedge clk);
    reset = 1'b1;
    m_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pr[k] && $urandom_range(0, 3) != 0) begin
          pr[k] = 1;
          pw[k] = ($urandom_range(0, 2) == 0);
          pa[k] = AW'($urandom_range(0, 15));
          pd[k] = $urandom;
        end
      end
      drive(pr[0], pw[0], pa[0], pd[0], pr[1], pw[1], pa[1], pd[1]);
      #1;
      g     = pick(pr[0], pr[1]);
      gi    = (g < 0) ? 0 : g;
      eg    = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
      een   = (g >= 0);
      ewe   = een && pw[gi];
      eaddr = een ? pa[gi] : '0;
      ewd   = een ? pd[gi] : '0;
      tests++;
      if ({o_r1_gnt, o_r0_gnt} !== eg || o_mem_en !== een
          || o_mem_wr_en !== ewe || o_mem_addr !== eaddr
          || o_mem_wr_data !== ewd) begin
        fails++;
        $display("FAIL rand_port[%0d]: got g=%b%b en=%b we=%b a=%h d=%h want g=%b en=%b we=%b a=%h d=%h",
                 c, o_r1_gnt, o_r0_gnt, o_mem_en, o_mem_wr_en, o_mem_addr,
                 o_mem_wr_data, eg, een, ewe, eaddr, ewd);
      end
      tests++;
      if (o_r0_rvalid !== exp_rv[0] || o_r1_rvalid !== exp_rv[1]
          || o_r0_rd_data !== (exp_rv[0] ? exp_rd : '0)
          || o_r1_rd_data !== (exp_rv[1] ? exp_rd : '0)) begin
        fails++;
        $display("FAIL rand_ret[%0d]: got rv=%b%b d0=%h d1=%h want rv=%b%b d=%h",
                 c, o_r1_rvalid, o_r0_rvalid, o_r0_rd_data, o_r1_rd_data,
                 exp_rv[1], exp_rv[0], exp_rd);
      end
      m_commit(g, pw[gi], pa[gi], pd[gi]);
      if (g >= 0) pr[gi] = 0;
      @(negedge clk);
    end
    idle_in();
  endtask

  initial begin
    reset = 1'b0;
    idle_in();
    test_reset();
    test_single_read();
    test_burst();
    test_r1_saturate();
    test_alternating();
    test_idle();
    test_reset_mid();
    test_random();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
